// File: rtl/pmux_scan_if.sv
// Bus bundle for pmux_scan: channel inputs, manual/scan controls and the ready/valid output.
// ch_mask is present only when PMUX_SCAN_MASK_EN is defined.
interface pmux_scan_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int SW = $clog2(N);

  logic [N*W-1:0] din;
  logic [SW-1:0]  sel;
  logic           mode;
  logic           start;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [SW-1:0]  out_ch;
  logic           busy;
`ifdef PMUX_SCAN_MASK_EN
  logic [N-1:0]   ch_mask;
`endif

  modport master (
`ifdef PMUX_SCAN_MASK_EN
    output ch_mask,
`endif
    output din, sel, mode, start, out_ready,
    input  out_data, out_valid, out_ch, busy
  );

  modport slave (
`ifdef PMUX_SCAN_MASK_EN
    input  ch_mask,
`endif
    input  din, sel, mode, start, out_ready,
    output out_data, out_valid, out_ch, busy
  );
endinterface

// File: rtl/pmux_scan.sv
// N-channel sample mux: manual select or one-shot ascending scan with dwell, into a ready/valid register.
// Define PMUX_SCAN_MASK_EN to add ch_mask, restricting the sweep to enabled channels.
module pmux_scan #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int DWELL = 2
) (
  input logic         clk,
  input logic         rst,
  pmux_scan_if.slave  bus
);
  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {ST_IDLE, ST_SAMPLE, ST_WAIT_ACK, ST_DWELL} state_t;

  state_t        state_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_ch_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [SW-1:0] ch_q;
  logic [7:0]    cnt_q;
  logic [N-1:0]  mask_q;

  // Lowest enabled channel at or above 'from'; MSB of the result flags that one exists.
  function automatic logic [SW:0] next_en(input logic [N-1:0] m, input int from);
    logic [SW:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--)
      if (i >= from && m[i]) r = {1'b1, SW'(i)};
    return r;
  endfunction

  logic xfer, free;
  assign xfer = out_valid_q & bus.out_ready;
  assign free = ~out_valid_q | bus.out_ready;

  logic [N-1:0] mask_in;
`ifdef PMUX_SCAN_MASK_EN
  assign mask_in = bus.ch_mask;
`else
  assign mask_in = '1;
`endif

  logic [SW:0] first_en, next_ch;
  assign first_en = next_en(mask_in, 0);
  assign next_ch  = next_en(mask_q, int'(ch_q) + 1);

  // Out-of-range selects fall through the loop and read as zero.
  logic [W-1:0] man_data, ch_data;
  always_comb begin
    man_data = '0;
    ch_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.sel == SW'(i)) man_data = bus.din[i*W +: W];
      if (ch_q == SW'(i))    ch_data  = bus.din[i*W +: W];
    end
  end

  // Where the sweep goes once a sample is acknowledged and any dwell has expired.
  state_t        adv_state;
  logic [SW-1:0] adv_ch;
  logic          adv_busy;
  always_comb begin
    adv_state = ST_IDLE;
    adv_ch    = '0;
    adv_busy  = 1'b0;
    if (next_ch[SW]) begin
      adv_state = ST_SAMPLE;
      adv_ch    = next_ch[SW-1:0];
      adv_busy  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ch_q        <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer) out_valid_q <= 1'b0;
          if (!bus.mode) begin
            if (free) begin
              out_data_q  <= man_data;
              out_ch_q    <= bus.sel;
              out_valid_q <= 1'b1;
            end
          end else if (bus.start && first_en[SW]) begin
            state_q <= ST_SAMPLE;
            ch_q    <= first_en[SW-1:0];
            mask_q  <= mask_in;
            busy_q  <= 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (free) begin
            out_data_q  <= ch_data;
            out_ch_q    <= ch_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (xfer) begin
            out_valid_q <= 1'b0;
            if (DWELL == 0) begin
              state_q <= adv_state;
              ch_q    <= adv_ch;
              busy_q  <= adv_busy;
            end else begin
              cnt_q   <= 8'(DWELL);
              state_q <= ST_DWELL;
            end
          end
        end
        ST_DWELL: begin
          if (cnt_q <= 8'd1) begin
            cnt_q   <= '0;
            state_q <= adv_state;
            ch_q    <= adv_ch;
            busy_q  <= adv_busy;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/pmux_scan.md
PMUX_SCAN -- requirements
Module: pmux_scan

Interface
Parameters:
REQ-001 W, 8, data width per channel (1..32).
REQ-002 N, 4, channel count (2..16).
REQ-003 DWELL, 2, idle cycles between scan samples (0..255).
REQ-004 SW, derived as $clog2(N), select width; not user-overridable.
Ports:
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 din  in  N*W  channel i at din[i*W +: W].
REQ-008 sel  in  SW  manual channel select.
REQ-009 mode  in  1  0 = manual, 1 = scan.
REQ-010 start  in  1  single-cycle pulse that launches one scan sweep.
REQ-011 out_ready  in  1  downstream accepts out_data.
REQ-012 out_data  out  W  registered selected sample.
REQ-013 out_valid  out  1  out_data holds an unaccepted sample.
REQ-014 out_ch  out  SW  channel index of out_data.
REQ-015 busy  out  1  high while a scan sweep is in progress.

Function
REQ-016 The output register SHALL be free when out_valid=0 or (out_valid=1 and out_ready=1); a transfer SHALL occur when out_valid=1 and out_ready=1.
REQ-017 Manual mode, state IDLE, mode=0: when the register is free, the block SHALL capture din[sel] into out_data and sel into out_ch and set out_valid=1, giving one-cycle latency.
REQ-018 Manual mode: if sel>=N, out_data SHALL be 0, out_ch=sel and out_valid=1.
REQ-019 Manual mode with register not free: out_data, out_ch and out_valid SHALL hold, with no loss and no overwrite.
REQ-020 FSM states SHALL be IDLE, SAMPLE, WAIT_ACK and DWELL.
REQ-021 In IDLE, mode=1 and start=1 SHALL enter SAMPLE with ch=first enabled channel and busy=1 from the next cycle.
REQ-022 In SAMPLE, when the register is free, the block SHALL load din[ch] and ch and set out_valid=1, then go to WAIT_ACK.
REQ-023 In WAIT_ACK, on transfer, the block SHALL clear out_valid and go to DWELL with count=DWELL, or skip DWELL when DWELL=0.
REQ-024 DWELL SHALL decrement each cycle; at 0 it SHALL advance ch to the next enabled channel and go to SAMPLE, or go to IDLE with busy=0 if the last enabled channel is done.
REQ-025 The sweep order SHALL be ascending with no wrap; one start yields exactly one sample per enabled channel.
REQ-026 start while busy=1 SHALL be ignored, and mode and sel changes during a sweep SHALL be ignored until IDLE.
REQ-027 In IDLE with mode=1 and no start, no new samples SHALL be captured, and a pending out_valid SHALL still complete normally.
REQ-028 A start pulse and a transfer in the same IDLE cycle SHALL both take effect.

Reset
REQ-029 While rst=1, the block SHALL force state=IDLE, out_data=0, out_ch=0, out_valid=0, busy=0, ch=0 and count=0, independent of clk.
REQ-030 Reset asserted mid-sweep SHALL abandon the sweep, drop any pending sample, and require no further start.
REQ-031 Reset release SHALL be sampled synchronously, and the first capture SHALL occur no earlier than the first clk edge after release.

Configuration
REQ-032 Macro PMUX_SCAN_MASK_EN defined: the block SHALL add the input port ch_mask [N-1:0], and scan SHALL visit only channels whose mask bit is 1, with ch_mask sampled at start and held for the sweep.
REQ-033 With PMUX_SCAN_MASK_EN defined and ch_mask=0 at start, start SHALL be ignored and busy SHALL stay 0.
REQ-034 With PMUX_SCAN_MASK_EN undefined, the ch_mask port SHALL be absent and all N channels SHALL be visited; manual mode SHALL be unaffected by the macro.

Verification (W=8, N=4, DWELL=2)
REQ-035 Manual: din={8'h44,8'h33,8'h22,8'h11}, sel=2, out_ready=1 -> the cycle after, out_data=8'h33, out_ch=2, out_valid=1.
REQ-036 Backpressure: manual, out_ready=0 for 5 cycles while sel changes 0->3 -> out_data stays the first captured value; the first cycle with out_ready=1 transfers it and the next capture uses the current sel.
REQ-037 Scan: mode=1, start pulse, out_ready=1 -> transfers on ch 0,1,2,3 with values 11,22,33,44; busy=1 throughout; 2 dwell cycles between samples; busy=0 after ch 3.
REQ-038 Reset mid-sweep: assert rst during DWELL after ch 1 -> outputs 0 and busy=0 immediately; after release, no output until a new start or manual request.
REQ-039 Mask (PMUX_SCAN_MASK_EN): ch_mask=4'b1010, start -> only ch 1 and 3 are sampled; ch_mask=0, start -> busy stays 0 and no out_valid.
REQ-040 Start during sweep plus DWELL=0 build: second start ignored; samples arrive back-to-back on consecutive ready cycles.
